// File: rtl/par_rank_select.sv
// -----------------------------------------------------------------------------
// par_rank_select
//
// Captures a COL-entry vector in one beat and computes the rank of every entry
// against all others, one index per cycle. Each issued index runs through a
// COL-wide compare stage and a 4-input adder tree, and its rank is written into
// a TOPK-deep slot table. The TOPK highest-priority entries are then streamed
// out in rank order over a valid/ready interface.
//
// Priority: a beats b if v[a] < v[b] (ascending) or v[a] > v[b] (descending),
// with equal values resolved in favour of the lower index. The compare is
// two's-complement when SIGNED != 0.
//
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_data          packed input vector, entry j = i_data[j*IW +: IW]
//   i_dir           0 = ascending (smallest first), 1 = descending
//   i_valid/o_ready input vector handshake (o_ready high only in IDLE)
//   o_idx/o_data    index and captured value of the emitted entry
//   o_rank          rank of the emitted entry (0 = highest priority)
//   o_valid/i_ready output beat handshake
//   o_last          marks the rank TOPK-1 beat
//   o_busy          high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module par_rank_select #(
    parameter int IW     = 32,
    parameter int COL    = 64,
    parameter int TOPK   = 16,
    parameter int SIGNED = 0,
    parameter int IDX_W  = $clog2(COL),
    parameter int RK_W   = $clog2(COL) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [COL*IW-1:0]   i_data,
    input  logic                i_dir,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [IDX_W-1:0]    o_idx,
    output logic [IW-1:0]       o_data,
    output logic [RK_W-1:0]     o_rank,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_busy
);

    // Adder-tree depth: ceil(log4 COL), at least one stage.
    localparam int LOG4 = ($clog2(COL) + 1) / 2;
    localparam int NS   = (LOG4 < 1) ? 1 : LOG4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RANK,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [COL*IW-1:0]   vec_q, vec_d;
    logic                dir_q, dir_d;
    logic [IDX_W-1:0]    issue_idx_q, issue_idx_d;
    logic                issue_vld_q, issue_vld_d;
    logic [IDX_W-1:0]    emit_r_q, emit_r_d;
    logic                drained_q, drained_d;
    logic [IDX_W-1:0]    slot_q [TOPK];
    logic [IDX_W-1:0]    slot_d [TOPK];

    // Compare stage output: flag j set when entry j beats the issued index.
    logic [COL-1:0]      flag_p1_q, flag_p1_d;
    // Tags travelling with the data: element 0 = compare stage,
    // element s+1 = after adder stage s.
    logic [IDX_W-1:0]    tag_idx_q [NS+1];
    logic [IDX_W-1:0]    tag_idx_d [NS+1];
    logic [NS:0]         vld_pn_q, vld_pn_d;
    logic [NS:0]         tag_last_q, tag_last_d;
    // Adder tree partial sums, one row per stage.
    logic [RK_W-1:0]     sum_q [NS][COL];
    logic [RK_W-1:0]     sum_d [NS][COL];

    logic [IW-1:0]       v_issue;
    logic [RK_W-1:0]     rank_w;
    logic [IDX_W-1:0]    emit_sel;
    logic                emit;

    function automatic int node_cnt(input int lvl);
        int n;
        n = COL;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 3) / 4;
        end
        return n;
    endfunction

    // One extra bit lets a single signed compare cover both modes.
    function automatic logic beats(input logic [IW-1:0] va,
                                   input logic [IW-1:0] vb,
                                   input logic          a_lower,
                                   input logic          dir);
        logic signed [IW:0] sa;
        logic signed [IW:0] sb;
        logic               lt;
        logic               gt;
        sa = (SIGNED != 0) ? {va[IW-1], va} : {1'b0, va};
        sb = (SIGNED != 0) ? {vb[IW-1], vb} : {1'b0, vb};
        lt = (sa < sb);
        gt = (sa > sb);
        return (dir ? gt : lt) || ((va == vb) && a_lower);
    endfunction

    // -------------------------------------------------------------------------
    // Control: FSM, issue counter, emit pointer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dir_d       = dir_q;
        issue_idx_d = issue_idx_q;
        issue_vld_d = issue_vld_q;
        emit_r_d    = emit_r_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d     = S_RANK;
                    vec_d       = i_data;
                    dir_d       = i_dir;
                    issue_idx_d = '0;
                    issue_vld_d = 1'b1;
                end
            end
            S_RANK: begin
                if (issue_vld_q) begin
                    if (issue_idx_q == IDX_W'(COL - 1)) begin
                        issue_vld_d = 1'b0;
                    end else begin
                        issue_idx_d = issue_idx_q + 1'b1;
                    end
                end
                // Last slot write landed the previous cycle.
                if (drained_q) begin
                    state_d  = S_EMIT;
                    emit_r_d = '0;
                end
            end
            S_EMIT: begin
                if (i_ready) begin
                    if (emit_r_q == IDX_W'(TOPK - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        emit_r_d = emit_r_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p1: COL parallel compares against the issued entry
    // -------------------------------------------------------------------------
    always_comb begin
        v_issue = vec_q[int'(issue_idx_q) * IW +: IW];
        for (int j = 0; j < COL; j++) begin
            flag_p1_d[j] = (IDX_W'(j) != issue_idx_q) &&
                           beats(vec_q[j * IW +: IW], v_issue,
                                 IDX_W'(j) < issue_idx_q, dir_q);
        end
        vld_pn_d[0]   = issue_vld_q;
        tag_idx_d[0]  = issue_idx_q;
        tag_last_d[0] = (issue_idx_q == IDX_W'(COL - 1));
        for (int s = 1; s <= NS; s++) begin
            vld_pn_d[s]   = vld_pn_q[s-1];
            tag_idx_d[s]  = tag_idx_q[s-1];
            tag_last_d[s] = tag_last_q[s-1];
        end
    end

    // -------------------------------------------------------------------------
    // Adder stages: each node sums up to four children of the previous level
    // -------------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < COL; i++) begin
                sum_d[s][i] = '0;
            end
        end
        for (int k = 0; k < COL; k++) begin
            sum_d[0][k/4] = sum_d[0][k/4] + RK_W'(flag_p1_q[k]);
        end
        for (int s = 1; s < NS; s++) begin
            for (int k = 0; k < COL; k++) begin
                if (k < node_cnt(s)) begin
                    sum_d[s][k/4] = sum_d[s][k/4] + sum_q[s-1][k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Final stage: ranks below TOPK land in the slot table
    // -------------------------------------------------------------------------
    always_comb begin
        rank_w    = sum_q[NS-1][0];
        drained_d = vld_pn_q[NS] && tag_last_q[NS];
        for (int t = 0; t < TOPK; t++) begin
            slot_d[t] = slot_q[t];
            if (vld_pn_q[NS] && (rank_w == RK_W'(t))) begin
                slot_d[t] = tag_idx_q[NS];
            end
        end
    end

    // Outputs are gated by state so they read zero outside EMIT.
    always_comb begin
        emit     = (state_q == S_EMIT);
        emit_sel = '0;
        for (int t = 0; t < TOPK; t++) begin
            if (emit_r_q == IDX_W'(t)) begin
                emit_sel = slot_q[t];
            end
        end
        o_ready = (state_q == S_IDLE);
        o_busy  = (state_q != S_IDLE);
        o_valid = emit;
        o_idx   = emit ? emit_sel : '0;
        o_data  = emit ? vec_q[int'(emit_sel) * IW +: IW] : '0;
        o_rank  = emit ? RK_W'(emit_r_q) : '0;
        o_last  = emit && (emit_r_q == IDX_W'(TOPK - 1));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            issue_idx_q <= '0;
            issue_vld_q <= 1'b0;
            emit_r_q    <= '0;
            drained_q   <= 1'b0;
            vld_pn_q    <= '0;
            for (int t = 0; t < TOPK; t++) begin
                slot_q[t] <= '0;
            end
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            issue_vld_q <= issue_vld_d;
            emit_r_q    <= emit_r_d;
            drained_q   <= drained_d;
            vld_pn_q    <= vld_pn_d;
            slot_q      <= slot_d;
        end
    end

    // Datapath registers are qualified by the valids above and need no reset.
    always_ff @(posedge i_clk) begin
        vec_q      <= vec_d;
        dir_q      <= dir_d;
        flag_p1_q  <= flag_p1_d;
        tag_idx_q  <= tag_idx_d;
        tag_last_q <= tag_last_d;
        sum_q      <= sum_d;
    end

endmodule
